// File: rtl/rsa_pkg.sv
// Shared width constant and state encoding for the RSA exponentiation sequencer.
package rsa_pkg;

  localparam int RSA_WIDTH = 256;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_MONT = 2'd2,
    S_DONE = 2'd3
  } rsa_state_t;

endpackage

// File: rtl/rsa_exp_ctrl.sv
// Sequencer for a^d mod N: one Montgomery precompute, then WIDTH rounds of
// right-to-left square-and-multiply on parallel MUL/SQ Montgomery units.
module rsa_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_a_pow_d,
  output logic             o_finished,
  output logic             o_busy,
  output logic             mp_start,
  output logic [WIDTH-1:0] mp_y,
  output logic [WIDTH-1:0] mp_n,
  input  logic [WIDTH-1:0] mp_m,
  input  logic             mp_finish,
  output logic             mont_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic [WIDTH-1:0] sq_a,
  output logic [WIDTH-1:0] sq_b,
  output logic [WIDTH-1:0] mont_n,
  input  logic [WIDTH-1:0] mul_out,
  input  logic             mul_finish,
  input  logic [WIDTH-1:0] sq_out,
  input  logic             sq_finish
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  rsa_state_t       state_r;
  logic [WIDTH-1:0] a_r, d_r, n_r, m_r, t_r;
  logic [WIDTH-1:0] mul_res_r, sq_res_r, result_r;
  logic [CNT_W-1:0] cnt_r;
  logic             mul_done_r, sq_done_r;
  logic             finished_r, busy_r, mp_start_r, mont_start_r;

  logic             mul_ok_s, sq_ok_s;
  logic [WIDTH-1:0] mul_val_s, sq_val_s;

  // Combine a finish pulse arriving now with one already latched this round
  always_comb begin
    mul_ok_s  = mul_done_r | mul_finish;
    sq_ok_s   = sq_done_r | sq_finish;
    mul_val_s = mul_finish ? mul_out : mul_res_r;
    sq_val_s  = sq_finish ? sq_out : sq_res_r;
  end

  // Main sequencer: state, operand registers and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      a_r          <= ZERO_W;
      d_r          <= ZERO_W;
      n_r          <= ZERO_W;
      m_r          <= ZERO_W;
      t_r          <= ZERO_W;
      mul_res_r    <= ZERO_W;
      sq_res_r     <= ZERO_W;
      result_r     <= ZERO_W;
      cnt_r        <= {CNT_W{1'b0}};
      mul_done_r   <= 1'b0;
      sq_done_r    <= 1'b0;
      finished_r   <= 1'b0;
      busy_r       <= 1'b0;
      mp_start_r   <= 1'b0;
      mont_start_r <= 1'b0;
    end else begin
      mp_start_r   <= 1'b0;
      mont_start_r <= 1'b0;
      finished_r   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (i_start) begin
            a_r        <= i_a;
            d_r        <= i_d;
            n_r        <= i_n;
            result_r   <= ZERO_W;
            mp_start_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= S_PREP;
          end
        end
        S_PREP: begin
          if (mp_finish) begin
            t_r          <= mp_m;
            m_r          <= ONE_W;
            cnt_r        <= {CNT_W{1'b0}};
            mont_start_r <= 1'b1;
            state_r      <= S_MONT;
          end
        end
        S_MONT: begin
          if (mul_ok_s && sq_ok_s) begin
            // m stays in the plain domain because t carries the 2^WIDTH factor
            if (d_r[cnt_r]) begin
              m_r <= mul_val_s;
            end
            t_r        <= sq_val_s;
            mul_done_r <= 1'b0;
            sq_done_r  <= 1'b0;
            if (cnt_r == CNT_LAST) begin
              state_r <= S_DONE;
            end else begin
              cnt_r        <= cnt_r + CNT_ONE;
              mont_start_r <= 1'b1;
            end
          end else begin
            mul_done_r <= mul_ok_s;
            sq_done_r  <= sq_ok_s;
            if (mul_finish) begin
              mul_res_r <= mul_out;
            end
            if (sq_finish) begin
              sq_res_r <= sq_out;
            end
          end
        end
        S_DONE: begin
          result_r   <= m_r;
          finished_r <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign o_a_pow_d  = result_r;
  assign o_finished = finished_r;
  assign o_busy     = busy_r;
  assign mp_start   = mp_start_r;
  assign mp_y       = a_r;
  assign mp_n       = n_r;
  assign mont_start = mont_start_r;
  assign mul_a      = m_r;
  assign mul_b      = t_r;
  assign sq_a       = t_r;
  assign sq_b       = t_r;
  assign mont_n     = n_r;

endmodule
